float2int: RTL and testbench
============================

# float2int

Sequential decoder for the 7-bit minifloat produced by the integer-to-float encoder: accepts one float word {exp[3:0], man[2:0]} and reconstructs the 11-bit unsigned integer using a one-bit-per-cycle shift datapath. Sits on the return path of the compressed-value interface, between the float link and integer consumers. It uses valid/ready handshakes on both sides and holds at most one operation in flight.

## Interface
- `F2I_IW`, default 11: integer output width. Fixed at 11 for this release.
- `clk` input 1: clock. All logic is rising-edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `in_valid` input 1: `in_float` is valid.
- `in_ready` output 1: block accepts input this cycle.
- `in_float` input 7: [6:3] = exponent `e`, [2:0] = mantissa `m`.
- `out_valid` output 1: `out_int` and `out_ovf` are valid.
- `out_ready` input 1: consumer accepts the output.
- `out_int` output 11: decoded integer.
- `out_ovf` output 1: exponent was out of range and the result was saturated.
- `busy` output 1: high in every state except IDLE.

## Operation
- Decode rule:
  - If `e`=0, the value is `m`, a subnormal in the range 0..7.
  - If `e`≥1, the value is {1'b1,m} << (e−1).
  - The representable range is `e` ≤ 8, with maximum value 0x780.
- FSM states are IDLE, SHIFT and DONE. The reset state is IDLE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`, the input is accepted:
    - The 11-bit accumulator loads `m` when `e`=0, otherwise {1,m} zero-extended.
    - The 4-bit counter `cnt` loads 0 when `e`=0, otherwise e−1.
  - If `cnt`=0, or on the saturation case (see Configuration), go to DONE. Otherwise go to SHIFT.
- **SHIFT**
  - Each cycle: accumulator <<= 1, with the MSB discarded, and `cnt` −= 1.
  - When `cnt`=1 at the start of the cycle, go to DONE after that cycle's shift.
- **DONE**
  - `out_valid`=1, and `out_int` shows the accumulator.
  - On `out_ready`, go to IDLE.
- `in_ready`=0 in SHIFT and DONE. Input is ignored in those states.
- `out_int`/`out_ovf` are registered and stay stable while `out_valid` is high and `out_ready` is low.
- After the output handshake, `out_int`/`out_ovf` retain their last values until the next DONE.
- Arithmetic is unsigned. No rounding is needed, because every decoded value is exact.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_int`=0, `out_ovf`=0, `busy`=0. The accumulator and `cnt` are cleared to 0 and the FSM returns to IDLE.
- Input accepted at cycle T means `in_valid` and `in_ready` are both high at the rising edge T.
- Latency: `out_valid` rises at T+1+`cnt`.
  - `e`≤1 gives T+1.
  - `e`=8 gives T+8.
  - The saturation case gives T+1.
- Throughput: the output handshake at edge D means `in_ready`=1 from D+1. The minimum issue interval is therefore 2 cycles, with no output/input overlap.
- Backpressure: DONE holds indefinitely with outputs frozen.
- Reset during SHIFT or DONE: on the next edge the block is IDLE with reset values. The in-flight operation is dropped and no `out_valid` is produced for it.
- `in_valid` while `in_ready`=0 has no effect. The upstream must hold the data stable until it is accepted.

## Configuration
- `F2I_SAT_EN` defined:
  - An input with `e`>8 goes directly to DONE with `out_int`=0x7FF and `out_ovf`=1. Latency is T+1.
  - For `e`≤8, `out_ovf`=0.
- `F2I_SAT_EN` undefined:
  - An input with `e`>8 shifts for e−1 cycles like any other exponent. Bits shifted past bit 10 are lost, so the result wraps modulo 2^11.
  - `out_ovf` is tied to 0.
  - Maximum latency is T+15 (`e`=15).

## Test plan
- Subnormal: `in_float`=7'b0000_101 → `out_valid` at T+1, `out_int`=5, `out_ovf`=0.
- Unit exponent: `in_float`=7'b0001_000 → `out_int`=8 at T+1. Then 7'b0100_011 → `out_int`=0x58 (88) at T+4.
- Maximum in range: `in_float`=7'b1000_111 → `out_int`=0x780 at T+8, with `busy`=1 and `in_ready`=0 for cycles T+1..T+8.
- Out of range: `in_float`=7'b1100_000.
  - With `F2I_SAT_EN` → `out_int`=0x7FF, `out_ovf`=1 at T+1.
  - Without `F2I_SAT_EN` → `out_int`=0x000, `out_ovf`=0 at T+12.
- Backpressure: 7'b0010_001 with `out_ready` held low for 5 cycles → `out_valid`=1 and `out_int`=0x12 stable throughout, and `in_ready`=0. When `out_ready` goes high, `in_ready`=1 on the next cycle.
- Reset mid-shift: apply `rst_n`=0 at T+3 of a 7'b0111_000 decode → next cycle `out_valid`=0, `out_int`=0, `in_ready`=1, `busy`=0, and no spurious output follows.

Source files
------------

// File: rtl/float2int.sv
// Sequential minifloat {exp[3:0], man[2:0]} to unsigned integer decoder, one shift per cycle.
// Optional saturation of out-of-range exponents is enabled by defining F2I_SAT_EN.
module float2int #(
  parameter int F2I_IW = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_float,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [F2I_IW-1:0] out_int,
  output logic              out_ovf,
  output logic              busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [F2I_IW-1:0] acc_q, acc_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [F2I_IW-1:0] out_int_q, out_int_d;
  logic              out_ovf_q, out_ovf_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic [3:0]        exp_s;
  logic [2:0]        man_s;
  logic              sat_s;

  assign exp_s = in_float[6:3];
  assign man_s = in_float[2:0];

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    out_int_d = out_int_q;
    out_ovf_d = out_ovf_q;
`ifdef F2I_SAT_EN
    sat_s = (exp_s > 4'd8);
`else
    sat_s = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (exp_s == 4'd0) begin
            acc_d = {{(F2I_IW-3){1'b0}}, man_s};
            cnt_d = 4'd0;
          end else begin
            acc_d = {{(F2I_IW-4){1'b0}}, 1'b1, man_s};
            cnt_d = exp_s - 4'd1;
          end
          if (sat_s) begin
            state_d   = DONE;
            out_int_d = {F2I_IW{1'b1}};
            out_ovf_d = 1'b1;
          end else if (cnt_d == 4'd0) begin
            state_d   = DONE;
            out_int_d = acc_d;
            out_ovf_d = 1'b0;
          end else begin
            state_d = SHIFT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        // Bits pushed past the MSB are dropped: out-of-range exponents wrap when not saturating.
        acc_d = {acc_q[F2I_IW-2:0], 1'b0};
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d   = DONE;
          out_int_d = acc_d;
          out_ovf_d = 1'b0;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= {F2I_IW{1'b0}};
      cnt_q       <= 4'd0;
      out_int_q   <= {F2I_IW{1'b0}};
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_int_q   <= out_int_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_int   = out_int_q;
  assign out_ovf   = out_ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_float2int.sv
// Self-checking bench for float2int: directed test-plan vectors plus randomized decodes
// checked against an arithmetic reference model.
module tb_float2int;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_float;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] out_int;
  logic        out_ovf;
  logic        busy;

  int n_cmp;
  int n_bad;

  float2int #(.F2I_IW(11)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_float (in_float),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_int  (out_int),
    .out_ovf  (out_ovf),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: value, overflow flag and latency from the decode rules.
  function automatic int ref_value(input logic [6:0] f);
    int e;
    int m;
    e = int'(f[6:3]);
    m = int'(f[2:0]);
`ifdef F2I_SAT_EN
    if (e > 8) return 2047;
`endif
    if (e == 0) return m;
    return ((8 + m) << (e - 1)) % 2048;
  endfunction

  function automatic int ref_ovf(input logic [6:0] f);
`ifdef F2I_SAT_EN
    if (int'(f[6:3]) > 8) return 1;
`endif
    return 0;
  endfunction

  function automatic int ref_lat(input logic [6:0] f);
    int e;
    e = int'(f[6:3]);
`ifdef F2I_SAT_EN
    if (e > 8) return 1;
`endif
    if (e <= 1) return 1;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full decode: accept, wait for out_valid, hold off out_ready, then handshake.
  task automatic do_op(input logic [6:0] f, input int hold);
    int lat;
    int exp_v;
    exp_v = ref_value(f);
    check("ready_before", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_float = f;
    tick();
    in_valid = 1'b0;
    in_float = 7'd0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      check("in_ready_busy", 32'(in_ready), 32'd0);
      check("busy_wait", 32'(busy), 32'd1);
      tick();
      lat++;
    end
    check("latency", 32'(lat), 32'(ref_lat(f)));
    check("out_valid", 32'(out_valid), 32'd1);
    check("out_int", 32'(out_int), 32'(exp_v));
    check("out_ovf", 32'(out_ovf), 32'(ref_ovf(f)));
    check("in_ready_done", 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_int", 32'(out_int), 32'(exp_v));
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
    check("post_busy", 32'(busy), 32'd0);
    check("post_hold_int", 32'(out_int), 32'(exp_v));
  endtask

  initial begin
    logic [6:0] f;
    int spurious;
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_float  = 7'd0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_int", 32'(out_int), 32'd0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();

    do_op(7'b0000_101, 0);
    do_op(7'b0001_000, 0);
    do_op(7'b0100_011, 0);
    do_op(7'b1000_111, 0);
    do_op(7'b1100_000, 0);
    do_op(7'b1111_111, 1);
    do_op(7'b0010_001, 5);

    // Reset in the middle of a shift.
    in_valid = 1'b1;
    in_float = 7'b0111_000;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_out_int", 32'(out_int), 32'd0);
    check("mrst_in_ready", 32'(in_ready), 32'd1);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_out_ovf", 32'(out_ovf), 32'd0);
    rst_n = 1'b1;
    spurious = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) spurious++;
    end
    check("mrst_no_output", 32'(spurious), 32'd0);

    for (int k = 0; k < 200; k++) begin
      f = 7'($urandom_range(0, 127));
      do_op(f, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
